// File: rtl/gtwiz_userclk_rx_drp_ctrl.sv
// gtwiz_userclk_rx_drp_ctrl
// DRP initiator for the RX user-clock PLL. It takes one read or masked-write
// command at a time and runs the DRP handshake. A masked write is done as a
// read-modify-write. It gives up on a silent PLL after TIMEOUT_CYCLES wait
// cycles and returns exactly one response per accepted command.
`timescale 1ns/1ps

module gtwiz_userclk_rx_drp_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        gtwiz_userclk_rx_usrclk2_out,
    input  logic        gtwiz_userclk_rx_reset_in,

    // Fabric command / response side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic [15:0] cmd_mask,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        err_spurious,

    // PLL DRP side
    output logic        drpen,
    output logic        drpwe,
    output logic [6:0]  drpaddr,
    output logic [15:0] drpdi,
    input  logic [15:0] drpdo,
    input  logic        drprdy
);

    // The wait counter only ever has to hold values up to TIMEOUT_CYCLES.
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value in the last wait cycle. The wait cycles are numbered
    // 0 .. TIMEOUT_CYCLES-1, so the response lands TIMEOUT_CYCLES cycles
    // after the WAIT state is entered.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        RESP
    } state_t;

    state_t            state_q;
    state_t            next_state;

    // Command latched in the accept cycle. The inputs are free to change after that.
    logic              cmd_write_q;
    logic [6:0]        addr_q;
    logic [15:0]       data_q;
    logic [15:0]       mask_q;

    logic [15:0]       drpdi_q;
    logic [15:0]       rsp_data_q;
    logic              timed_out_q;
    logic              rd_hit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cmd_ready_q;
    logic              err_spurious_q;

    logic              accept;
    logic              wait_last;
    logic              spurious;
    logic [15:0]       merged;

    // Read-modify-write merge: set mask bits come from the command and clear
    // mask bits keep the current register value.
    assign merged    = (drpdo & ~mask_q) | (data_q & mask_q);
    assign wait_last = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge gtwiz_userclk_rx_usrclk2_out or posedge gtwiz_userclk_rx_reset_in) begin
        if (gtwiz_userclk_rx_reset_in) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= next_state;
        end
    end

    // Next-state logic and the DRP strobes, which are decoded from the state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        next_state  = state_q;
        accept      = 1'b0;
        drpen       = 1'b0;
        drpwe       = 1'b0;
        rsp_valid   = 1'b0;
        rsp_timeout = 1'b0;
        spurious    = 1'b0;

        case (state_q)
            IDLE: begin
                spurious = drprdy;
                if (cmd_valid && cmd_ready_q) begin
                    accept     = 1'b1;
                    next_state = RD_REQ;
                end
            end

            RD_REQ: begin
                spurious   = drprdy;
                drpen      = 1'b1;
                next_state = RD_WAIT;
            end

            RD_WAIT: begin
                // A read completion spends one extra cycle here. The captured
                // data then drives rsp_data straight from a flop in RESP.
                if (rd_hit_q) begin
                    next_state = RESP;
                end else if (drprdy) begin
                    // drprdy beats a timeout that falls in the same cycle.
                    next_state = cmd_write_q ? WR_REQ : RD_WAIT;
                end else if (wait_last) begin
                    // A read timeout skips the write phase.
                    next_state = RESP;
                end
            end

            WR_REQ: begin
                spurious   = drprdy;
                drpen      = 1'b1;
                drpwe      = 1'b1;
                next_state = WR_WAIT;
            end

            WR_WAIT: begin
                if (drprdy || wait_last) begin
                    next_state = RESP;
                end
            end

            RESP: begin
                spurious    = drprdy;
                rsp_valid   = 1'b1;
                rsp_timeout = timed_out_q;
                next_state  = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command capture, wait counter, DRP data and response registers.
    always_ff @(posedge gtwiz_userclk_rx_usrclk2_out or posedge gtwiz_userclk_rx_reset_in) begin
        if (gtwiz_userclk_rx_reset_in) begin
            // NOTE: the data registers are reset as well, because drpaddr, drpdi and rsp_data must read 0 during reset.
            cmd_write_q    <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            mask_q         <= '0;
            drpdi_q        <= '0;
            rsp_data_q     <= '0;
            timed_out_q    <= 1'b0;
            rd_hit_q       <= 1'b0;
            cnt_q          <= '0;
            cmd_ready_q    <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            // cmd_ready is registered. It stays low through reset and rises
            // on the first clock after reset is released.
            cmd_ready_q <= (next_state == IDLE);

            if (spurious) begin
                err_spurious_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmd_write_q <= cmd_write;
                        addr_q      <= cmd_addr;
                        data_q      <= cmd_data;
                        mask_q      <= cmd_mask;
                        timed_out_q <= 1'b0;
                        rd_hit_q    <= 1'b0;
                    end
                end

                RD_REQ, WR_REQ: begin
                    cnt_q <= '0;
                end

                RD_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (!rd_hit_q) begin
                        if (drprdy) begin
                            if (cmd_write_q) begin
                                drpdi_q <= merged;
                            end else begin
                                rsp_data_q <= drpdo;
                                rd_hit_q   <= 1'b1;
                            end
                        end else if (wait_last) begin
                            rsp_data_q  <= '0;
                            timed_out_q <= 1'b1;
                        end
                    end
                end

                WR_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (drprdy) begin
                        rsp_data_q <= drpdi_q;
                    end else if (wait_last) begin
                        rsp_data_q  <= '0;
                        timed_out_q <= 1'b1;
                    end
                end

                RESP: begin
                    rd_hit_q <= 1'b0;
                end

                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_data     = rsp_data_q;
    assign err_spurious = err_spurious_q;
    assign drpaddr      = addr_q;
    assign drpdi        = drpdi_q;

endmodule
